// File: rtl/fp16_pkg.sv
// Half-precision field layout and helpers shared by the add scheduler slice.
package fp16_pkg;

    localparam int FP16_W   = 16;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MANT_MSB = 9;
    localparam int MANT_LSB = 0;

    function automatic logic is_zero(input logic [FP16_W-1:0] a);
        return (a[EXP_MSB:EXP_LSB] == '0) && (a[MANT_MSB:MANT_LSB] == '0);
    endfunction

endpackage

// File: rtl/fp16_add_scheduler_if.sv
// Two requester ports and one result port of the shared fp16 adder.
interface fp16_add_scheduler_if;
    import fp16_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_add;
    logic [FP16_W-1:0] req0_a;
    logic [FP16_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_add;
    logic [FP16_W-1:0] req1_a;
    logic [FP16_W-1:0] req1_b;
    logic              res_valid;
    logic              res_ready;
    logic [FP16_W-1:0] res_data;
    logic              res_tag;
    logic              res_bypass;
    logic              busy;

    modport slave (
        input  req0_valid, req0_add, req0_a, req0_b,
        input  req1_valid, req1_add, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_tag, res_bypass, busy
    );

    modport master (
        output req0_valid, req0_add, req0_a, req0_b,
        output req1_valid, req1_add, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_tag, res_bypass, busy
    );

endinterface

// File: rtl/fp16_add_scheduler_arb.sv
// Two-way arbiter; the pointer names the last winner, so ptr==1 favours req0.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       rr_enable,
    output logic [1:0] grant
);
    logic ptr;
    logic g0;

    assign g0       = req[0] & (~req[1] | ~rr_enable | ptr);
    assign grant[0] = g0;
    assign grant[1] = req[1] & ~g0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            ptr <= grant[1];
        end
    end

endmodule

// File: rtl/fp16_add_scheduler_fadder.sv
// Combinational fp16 adder for normal operands; round to nearest even, exact cancellation gives +0.
module FAdder_HalfPrecision
    import fp16_pkg::*;
(
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [MANT_W-1:0] a_mant,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [MANT_W-1:0] b_mant,
    output logic              s_sign,
    output logic [EXP_W-1:0]  s_exp,
    output logic [MANT_W-1:0] s_mant
);
    // Mantissas carry hidden bit, 10 fraction bits, guard, round and sticky.
    function automatic logic [13:0] align(input logic [13:0] m, input logic [EXP_W-1:0] d);
        logic sticky;
        if (d >= 5'd14) return 14'd1;
        sticky = |(m & ((14'd1 << d) - 14'd1));
        return (m >> d) | {13'b0, sticky};
    endfunction

    function automatic logic round_up(input logic lsb, input logic g, input logic rs);
        return g & (rs | lsb);
    endfunction

    logic              a_ge_b;
    logic              big_sign;
    logic [EXP_W-1:0]  big_exp;
    logic [EXP_W-1:0]  exp_n;
    logic [13:0]       big_m;
    logic [13:0]       sml_m;
    logic [14:0]       sum;
    logic [13:0]       norm;
    logic [3:0]        lz;
    logic              found;
    logic [11:0]       rnd;

    always_comb begin
        a_ge_b   = {a_exp, a_mant} >= {b_exp, b_mant};
        big_sign = a_ge_b ? a_sign : b_sign;
        big_exp  = a_ge_b ? a_exp : b_exp;
        big_m    = {1'b1, (a_ge_b ? a_mant : b_mant), 3'b000};
        sml_m    = align({1'b1, (a_ge_b ? b_mant : a_mant), 3'b000},
                         a_ge_b ? (a_exp - b_exp) : (b_exp - a_exp));
        sum      = (a_sign ^ b_sign) ? ({1'b0, big_m} - {1'b0, sml_m})
                                     : ({1'b0, big_m} + {1'b0, sml_m});
        lz    = 4'd0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 4'(13 - i);
                found = 1'b1;
            end
        end
        if (sum[14]) begin
            norm  = {sum[14:2], sum[1] | sum[0]};
            exp_n = big_exp + 5'd1;
        end else begin
            norm  = sum[13:0] << lz;
            exp_n = big_exp - {1'b0, lz};
        end
        rnd = {1'b0, norm[13:3]} + {11'b0, round_up(norm[3], norm[2], |norm[1:0])};
        if (sum == '0) begin
            s_sign = 1'b0;
            s_exp  = '0;
            s_mant = '0;
        end else if (rnd[11]) begin
            s_sign = big_sign;
            s_exp  = exp_n + 5'd1;
            s_mant = rnd[10:1];
        end else begin
            s_sign = big_sign;
            s_exp  = exp_n;
            s_mant = rnd[9:0];
        end
    end

endmodule

// File: rtl/fp16_add_scheduler.sv
// Two requesters share one fp16 adder through an issue stage and a result stage with backpressure.
module fp16_add_scheduler
    import fp16_pkg::*;
#(
    parameter bit RR_ENABLE   = 1'b1,
    parameter bit BYPASS_ZERO = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    fp16_add_scheduler_if.slave bus
);
    logic              s2_adv, s1_adv, accept, hs;
    logic [1:0]        grant;
    logic              vld_p1, tag_p1, add_p1;
    logic [FP16_W-1:0] a_p1, b_p1, b_eff;
    logic              vld_p2, tag_p2, byp_p2;
    logic [FP16_W-1:0] data_p2;
    logic              sum_sign;
    logic [EXP_W-1:0]  sum_exp;
    logic [MANT_W-1:0] sum_mant;
    logic [FP16_W-1:0] mux_data;
    logic              mux_byp;

    assign s2_adv = ~vld_p2 | bus.res_ready;
    assign s1_adv = vld_p1 & s2_adv;
    assign accept = ~vld_p1 | s2_adv;
    assign hs     = accept & (grant != 2'b00);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({bus.req1_valid, bus.req0_valid}),
        .advance   (accept),
        .rr_enable (RR_ENABLE),
        .grant     (grant)
    );

    assign bus.req0_ready = accept & grant[0];
    assign bus.req1_ready = accept & grant[1];

    // Issue stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vld_p1 <= 1'b0;
        else if (accept) vld_p1 <= hs;
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            tag_p1 <= grant[1];
            add_p1 <= grant[1] ? bus.req1_add : bus.req0_add;
            a_p1   <= grant[1] ? bus.req1_a   : bus.req0_a;
            b_p1   <= grant[1] ? bus.req1_b   : bus.req0_b;
        end
    end

    assign b_eff = {b_p1[SIGN_BIT] ^ ~add_p1, b_p1[SIGN_BIT-1:0]};

    FAdder_HalfPrecision u_fadd (
        .a_sign (a_p1[SIGN_BIT]),
        .a_exp  (a_p1[EXP_MSB:EXP_LSB]),
        .a_mant (a_p1[MANT_MSB:MANT_LSB]),
        .b_sign (b_eff[SIGN_BIT]),
        .b_exp  (b_eff[EXP_MSB:EXP_LSB]),
        .b_mant (b_eff[MANT_MSB:MANT_LSB]),
        .s_sign (sum_sign),
        .s_exp  (sum_exp),
        .s_mant (sum_mant)
    );

    // The adder assumes a hidden leading 1, so zero operands are resolved here.
    always_comb begin
        mux_data = {sum_sign, sum_exp, sum_mant};
        mux_byp  = 1'b0;
        if (BYPASS_ZERO) begin
            if (is_zero(a_p1) && is_zero(b_eff)) begin
                mux_data = {a_p1[SIGN_BIT] & b_eff[SIGN_BIT], 15'b0};
                mux_byp  = 1'b1;
            end else if (is_zero(b_eff)) begin
                mux_data = a_p1;
                mux_byp  = 1'b1;
            end else if (is_zero(a_p1)) begin
                mux_data = b_eff;
                mux_byp  = 1'b1;
            end
        end
    end

    // Result stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            tag_p2  <= 1'b0;
            byp_p2  <= 1'b0;
            data_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (s1_adv) begin
                tag_p2  <= tag_p1;
                byp_p2  <= mux_byp;
                data_p2 <= mux_data;
            end
        end
    end

    assign bus.res_valid  = vld_p2;
    assign bus.res_data   = data_p2;
    assign bus.res_tag    = tag_p2;
    assign bus.res_bypass = byp_p2;
    assign bus.busy       = vld_p1 | vld_p2;

endmodule

// File: tb/tb_fp16_add_scheduler.sv
// Directed bench for fp16_add_scheduler: vector table plus contention, stall and reset sequences.
module tb_fp16_add_scheduler;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp16_add_scheduler_if bus0 ();
    fp16_add_scheduler_if bus1 ();

    fp16_add_scheduler #(.RR_ENABLE(1'b1), .BYPASS_ZERO(1'b1)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0)
    );
    fp16_add_scheduler #(.RR_ENABLE(1'b0), .BYPASS_ZERO(1'b1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic        add;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        byp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic port, input logic v, input logic add,
                           input logic [15:0] a, input logic [15:0] b);
        if (port == 1'b0) begin
            bus0.req0_valid = v; bus0.req0_add = add; bus0.req0_a = a; bus0.req0_b = b;
        end else begin
            bus0.req1_valid = v; bus0.req1_add = add; bus0.req1_a = a; bus0.req1_b = b;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic rdy;
        @(posedge clk); #1;
        set_req(v.port, 1'b1, v.add, v.a, v.b);
        @(negedge clk);
        rdy = v.port ? bus0.req1_ready : bus0.req0_ready;
        chk($sformatf("vec%0d_ready", idx), {15'b0, rdy}, 16'd1);
        @(posedge clk); #1;
        set_req(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk($sformatf("vec%0d_early", idx), {15'b0, bus0.res_valid}, 16'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_valid", idx), {15'b0, bus0.res_valid}, 16'd1);
        chk($sformatf("vec%0d_data", idx), bus0.res_data, v.data);
        chk($sformatf("vec%0d_tag", idx), {15'b0, bus0.res_tag}, {15'b0, v.port});
        chk($sformatf("vec%0d_bypass", idx), {15'b0, bus0.res_bypass}, {15'b0, v.byp});
    endtask

    initial begin
        logic [15:0] held_data;
        logic        held_tag;
        int          acc;

        vecs[0]  = '{1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h4000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h4200, 16'h3C00, 16'h4000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h3C00, 16'hBC00, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 16'h8000, 16'h8000, 16'h8000, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 16'h4500, 16'h0000, 16'h4500, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 16'h4000, 16'h3C00, 16'h4200, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 16'hC000, 16'h3C00, 16'hBC00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h3C00, 16'h1400, 16'h3C01, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'h3C00, 16'h1000, 16'h3C00, 1'b0};

        bus0.req0_valid = 0; bus0.req0_add = 0; bus0.req0_a = 0; bus0.req0_b = 0;
        bus0.req1_valid = 0; bus0.req1_add = 0; bus0.req1_a = 0; bus0.req1_b = 0;
        bus0.res_ready  = 1;
        bus1.req0_valid = 0; bus1.req0_add = 0; bus1.req0_a = 0; bus1.req0_b = 0;
        bus1.req1_valid = 0; bus1.req1_add = 0; bus1.req1_a = 0; bus1.req1_b = 0;
        bus1.res_ready  = 1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", {15'b0, bus0.res_valid}, 16'd0);
        chk("rst_busy", {15'b0, bus0.busy}, 16'd0);
        chk("rst_res_data", bus0.res_data, 16'h0000);
        chk("rst_res_tag", {15'b0, bus0.res_tag}, 16'd0);
        chk("rst_res_bypass", {15'b0, bus0.res_bypass}, 16'd0);
        rst_n = 1'b1;

        // Contention: round-robin on dut0, fixed priority on dut1
        @(posedge clk); #1;
        bus0.req0_valid = 1; bus0.req0_add = 1; bus0.req0_a = 16'h3C00; bus0.req0_b = 16'h3C00;
        bus0.req1_valid = 1; bus0.req1_add = 1; bus0.req1_a = 16'h4000; bus0.req1_b = 16'h4000;
        bus1.req0_valid = 1; bus1.req0_add = 1; bus1.req0_a = 16'h3C00; bus1.req0_b = 16'h3C00;
        bus1.req1_valid = 1; bus1.req1_add = 1; bus1.req1_a = 16'h4000; bus1.req1_b = 16'h4000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rr_req0_ready_%0d", i), {15'b0, bus0.req0_ready}, {15'b0, (i % 2) == 0});
            chk($sformatf("rr_req1_ready_%0d", i), {15'b0, bus0.req1_ready}, {15'b0, (i % 2) == 1});
            chk($sformatf("rr_res_valid_%0d", i), {15'b0, bus0.res_valid}, {15'b0, i >= 2});
            chk($sformatf("fp_req0_ready_%0d", i), {15'b0, bus1.req0_ready}, 16'd1);
            chk($sformatf("fp_req1_ready_%0d", i), {15'b0, bus1.req1_ready}, 16'd0);
            if (i >= 2) begin
                chk($sformatf("rr_tag_%0d", i), {15'b0, bus0.res_tag}, {15'b0, (i % 2) == 1});
                chk($sformatf("rr_data_%0d", i), bus0.res_data, ((i % 2) == 1) ? 16'h4400 : 16'h4000);
                chk($sformatf("fp_tag_%0d", i), {15'b0, bus1.res_tag}, 16'd0);
                chk($sformatf("fp_data_%0d", i), bus1.res_data, 16'h4000);
            end
        end
        @(posedge clk); #1;
        bus0.req0_valid = 0; bus0.req1_valid = 0;
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Backpressure: two slots fill, then accepts stop until res_ready rises
        @(posedge clk); #1;
        bus0.res_ready = 0;
        bus0.req0_valid = 1; bus0.req0_add = 1; bus0.req0_a = 16'h3C00; bus0.req0_b = 16'h3C00;
        bus0.req1_valid = 1; bus0.req1_add = 1; bus0.req1_a = 16'h4000; bus0.req1_b = 16'h4000;
        acc = 0;
        held_data = 16'h0;
        held_tag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus0.req0_ready || bus0.req1_ready) acc++;
            chk($sformatf("bp_accept_%0d", i), {15'b0, bus0.req0_ready | bus0.req1_ready}, {15'b0, i < 2});
            if (i == 2) begin
                held_data = bus0.res_data;
                held_tag  = bus0.res_tag;
                chk("bp_valid_2", {15'b0, bus0.res_valid}, 16'd1);
            end
            if (i == 3) begin
                chk("bp_valid_3", {15'b0, bus0.res_valid}, 16'd1);
                chk("bp_data_stable", bus0.res_data, held_data);
                chk("bp_tag_stable", {15'b0, bus0.res_tag}, {15'b0, held_tag});
            end
        end
        chk("bp_accept_count", 16'(acc), 16'd2);
        @(posedge clk); #1;
        bus0.res_ready = 1;
        @(negedge clk);
        chk("bp_resume", {15'b0, bus0.req0_ready | bus0.req1_ready}, 16'd1);
        chk("bp_data_at_resume", bus0.res_data, held_data);
        @(posedge clk); #1;
        bus0.req0_valid = 0; bus0.req1_valid = 0;
        repeat (4) @(posedge clk);

        // Reset mid-flight with both stages full; pointer left favouring req1
        #1;
        bus0.res_ready = 0;
        set_req(1'b1, 1'b1, 1'b1, 16'h3C00, 16'h3C00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("mid_busy_before", {15'b0, bus0.busy}, 16'd1);
        chk("mid_valid_before", {15'b0, bus0.res_valid}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_res_valid", {15'b0, bus0.res_valid}, 16'd0);
        chk("mid_busy", {15'b0, bus0.busy}, 16'd0);
        chk("mid_res_data", bus0.res_data, 16'h0000);
        chk("mid_res_tag", {15'b0, bus0.res_tag}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus0.res_ready = 1;
        bus0.req0_valid = 1; bus0.req0_add = 1; bus0.req0_a = 16'h3C00; bus0.req0_b = 16'h3C00;
        bus0.req1_valid = 1; bus0.req1_add = 1; bus0.req1_a = 16'h4000; bus0.req1_b = 16'h4000;
        @(negedge clk);
        chk("post_rst_req0_ready", {15'b0, bus0.req0_ready}, 16'd1);
        chk("post_rst_req1_ready", {15'b0, bus0.req1_ready}, 16'd0);
        @(posedge clk); #1;
        bus0.req0_valid = 0; bus0.req1_valid = 0;
        @(negedge clk);
        chk("post_rst_no_stale", {15'b0, bus0.res_valid}, 16'd0);
        @(negedge clk);
        chk("post_rst_valid", {15'b0, bus0.res_valid}, 16'd1);
        chk("post_rst_tag", {15'b0, bus0.res_tag}, 16'd0);
        chk("post_rst_data", bus0.res_data, 16'h4000);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp16_add_scheduler.md
Name: fp16_add_scheduler

Overview:
- Shares one combinational half-precision adder (FAdder_HalfPrecision) between two requesters.
- Arbitrates round-robin and registers operands into an issue stage.
- Registers the adder result into an output stage with valid/ready backpressure.
- Returns each result tagged with its requester.
- Bypasses the adder when either operand is exactly zero, because the adder assumes an implicit leading 1 and cannot represent zero inputs.

Parameters:
- RR_ENABLE, 1, 1 = round-robin between requesters; 0 = fixed priority, req0 always wins.
- BYPASS_ZERO, 1, 1 = zero-operand bypass enabled; 0 = all ops go through the adder.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_add  in  1  1 = A+B, 0 = A-B.
- req0_a  in  16  operand A, packed {sign, exp[5], mant[10]}.
- req0_b  in  16  operand B, same packing.
- req1_valid, req1_ready, req1_add, req1_a, req1_b: same widths and meanings as requester 0.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  16  packed result.
- res_tag  out  1  requester index of this result.
- res_bypass  out  1  result produced by zero bypass, not by the adder.
- busy  out  1  s1_valid | s2_valid.

Behaviour:
- Pipeline registers:
  - S1 (issue): s1_valid, tag, add, a, b.
  - S2 (result): s2_valid, tag, data, bypass.
  - res_valid = s2_valid; res_* outputs are driven directly from S2.
- Reset (async, rst_n=0):
  - s1_valid = s2_valid = 0; res_valid = 0; busy = 0.
  - res_data = 0, res_tag = 0, res_bypass = 0.
  - Round-robin pointer = 1, so req0 wins the first contention.
  - Reset mid-operation discards all in-flight ops; nothing is replayed.
- Flow control:
  - s2_adv = !s2_valid | res_ready.
  - s1_adv = s1_valid & s2_adv.
  - accept = !s1_valid | s2_adv.
- Arbitration:
  - grant0 = req0_valid & (!req1_valid | !RR_ENABLE | ptr==1).
  - grant1 = req1_valid & !grant0.
  - reqN_ready = accept & grantN. Ready depends combinationally on valid, by design.
  - At most one ready per cycle.
  - The pointer updates to the granted index only on an actual handshake. A stalled grant does not move the pointer.
- S1 load:
  - On handshake, capture the granted requester's add, a and b, and set tag.
  - If accept without handshake, s1_valid clears.
  - If !accept, S1 holds.
- Adder and S2:
  - The adder is fed combinationally from S1.
  - On s1_adv, S2 captures the bypass-mux output; when S1 is empty, s2_valid clears if res_ready.
  - S2 holds all fields while res_valid & !res_ready.
- Latency and throughput:
  - Handshake in cycle N gives res_valid in cycle N+2 with no stall.
  - Throughput is 1 op/cycle sustained.
  - Capacity is 2 ops; with res_ready low, the third request is not accepted.
- Zero bypass (BYPASS_ZERO=1). Zero means exp==0 && mant==0; b_eff = b with sign inverted when add=0.
  - B zero, A nonzero: result = a.
  - A zero, B nonzero: result = b_eff.
  - Both zero: result = {a.sign & b_eff.sign, 15'b0}.
  - res_bypass = 1 in all three cases, else 0.
- Not handled: denormal, Inf and NaN operands go to the adder unchanged; results are undefined, and the bench excludes them.
- Simultaneous events:
  - S2 drain, S1 advance and a new accept can all happen in one cycle.
  - Both requests valid: exactly one is granted.

Decomposition:
- Package fp16_pkg:
  - FP16_W = 16, EXP_W = 5, MANT_W = 10.
  - Field slice localparams (SIGN_BIT = 15, EXP_MSB/LSB, MANT_MSB/LSB).
  - Function is_zero(a).
- Sub-module rr_arbiter2:
  - Inputs: clk, rst_n, req[1:0], advance, rr_enable.
  - Output: grant[1:0].
  - Contains the pointer register.
- Top-level contents:
  - Instantiates rr_arbiter2 and FAdder_HalfPrecision, which takes unpacked sign/exp/mant.
  - Contains the S1/S2 registers and the bypass mux.

Test Plan:
- Single add: req0 a=0x3C00, b=0x3C00, add=1 at cycle 0 -> cycle 2 res_valid=1, res_data=0x4000, res_tag=0, res_bypass=0.
- Subtract: req1 a=0x4200, b=0x3C00, add=0 -> res_data=0x4000, res_tag=1 two cycles later.
- Contention: both valid every cycle with res_ready=1 -> tags alternate 0,1,0,1 from the first result; with RR_ENABLE=0, all tags are 0 and req1_ready stays 0.
- Backpressure: res_ready=0 for 4 cycles with both valid -> exactly 2 accepts; res_data/res_tag are stable while stalled; accepts resume the cycle res_ready rises.
- Zero bypass: req0 a=0x0000, b=0x3C00, add=0 -> res_data=0xBC00, res_bypass=1. Also a=0x8000, b=0x8000, add=1 -> 0x8000.
- Reset mid-flight: S1 and S2 full, assert rst_n=0 asynchronously -> res_valid and busy drop immediately; after release, the first contention grants req0.
